i2s_rcvr_cntlr: RTL and testbench

//   I2S receive-side controller with word capture: consumes one-clk SCK rising-edge pulses, the

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_rcvr_sipo.sv | 37 +++
 rtl/i2s_rcvr_cntlr.sv | 168 ++++++++++++++++
 tb/tb_i2s_rcvr_cntlr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : i2s_pkg                                              |
// | Description : Shared I2S types and constants for the transmitter   |
// |               and receiver controllers.                            |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package i2s_pkg;

  // Default channel word width, shared by transmitter and receiver
  localparam int c_DATA_WIDTH = 16;

  // Receiver controller states
  typedef enum logic [1:0] {
    INIT = 2'd0,  // waiting for the first SCK edge to load ws_prev
    SYNC = 2'd1,  // waiting for the first WS change
    RECV = 2'd2,  // shifting slot bits in
    HOLD = 2'd3   // word full, remaining slot bits ignored
  } rcvr_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_rcvr_sipo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : i2s_rcvr_sipo                                        |
// | Description : Serial-in parallel-out shift register, MSB-first.    |
// |               clear has priority over shift.                       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module i2s_rcvr_sipo
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic                  clear,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] r_q;

  // Shift register: clear starts a new word, shift appends sd at the LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (shift) begin
      r_q <= {r_q[DATA_WIDTH-2:0], sd};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/i2s_rcvr_cntlr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : i2s_rcvr_cntlr                                       |
// | Description : I2S receive controller. Frames MSB-first serial data |
// |               into left-justified left/right words on SCK edges.   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module i2s_rcvr_cntlr
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck_rise,
  input  logic                  ws,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] word_data,
  output logic                  word_chan,
  output logic                  word_valid,
  output logic                  short_word,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  frame_ready
);

  localparam int                 c_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  rcvr_state_t           r_state, w_state_next;
  logic                  r_ws_prev;
  logic [c_CNT_W-1:0]    r_bit_cnt, w_bit_cnt_next;
  logic                  r_chan, w_chan_next;
  logic                  w_chg;
  logic                  w_shift, w_clear;
  logic                  w_publish, w_pub_short;
  logic [DATA_WIDTH-1:0] w_sr_q;
  logic [c_CNT_W-1:0]    w_shamt;
  logic [DATA_WIDTH-1:0] w_justified;

  logic [DATA_WIDTH-1:0] r_word_data, r_left_data, r_right_data;
  logic                  r_word_chan, r_word_valid, r_short_word;
  logic                  r_frame_ready, r_left_seen;

  i2s_rcvr_sipo #(.DATA_WIDTH(DATA_WIDTH)) u_sipo (
    .clk   (clk),
    .rst   (rst),
    .shift (w_shift),
    .clear (w_clear),
    .sd    (sd),
    .q     (w_sr_q)
  );

  assign w_chg = ws ^ r_ws_prev;

  // The final bit arrives on the publishing edge and is not yet in the
  // shift register, so it is merged here; the result is left-justified
  // by the number of bit positions that never arrived.
  assign w_shamt     = c_LAST - r_bit_cnt;
  assign w_justified = (w_sr_q << (w_shamt + c_ONE)) | (DATA_WIDTH'(sd) << w_shamt);

  // State, bit counter, channel and previous-WS registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= INIT;
      r_ws_prev <= 1'b0;
      r_bit_cnt <= '0;
      r_chan    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_chan    <= w_chan_next;
      if (sck_rise) begin
        r_ws_prev <= ws;
      end
    end
  end

  // Next-state, counter and shift/publish decisions per SCK edge
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_chan_next    = r_chan;
    w_shift        = 1'b0;
    w_clear        = 1'b0;
    w_publish      = 1'b0;
    w_pub_short    = 1'b0;
    if (sck_rise) begin
      case (r_state)
        INIT: begin
          w_state_next = SYNC;
        end
        SYNC, HOLD: begin
          if (w_chg) begin
            w_state_next   = RECV;
            w_bit_cnt_next = '0;
            w_chan_next    = ws;
            w_clear        = 1'b1;
          end
        end
        RECV: begin
          if (w_chg) begin
            // sd is the LSB of the ending slot
            w_publish      = 1'b1;
            w_pub_short    = (r_bit_cnt != c_LAST);
            w_bit_cnt_next = '0;
            w_chan_next    = ws;
            w_clear        = 1'b1;
          end else if (r_bit_cnt == c_LAST) begin
            w_publish      = 1'b1;
            w_clear        = 1'b1;
            w_bit_cnt_next = r_bit_cnt + c_ONE;
            w_state_next   = HOLD;
          end else begin
            w_shift        = 1'b1;
            w_bit_cnt_next = r_bit_cnt + c_ONE;
          end
        end
        default: begin
          w_state_next = INIT;
        end
      endcase
    end
  end

  // Registered publish: word outputs, per-channel words and frame pairing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_data   <= '0;
      r_word_chan   <= 1'b0;
      r_word_valid  <= 1'b0;
      r_short_word  <= 1'b0;
      r_left_data   <= '0;
      r_right_data  <= '0;
      r_frame_ready <= 1'b0;
      r_left_seen   <= 1'b0;
    end else begin
      r_word_valid  <= w_publish;
      r_frame_ready <= 1'b0;
      if (w_publish) begin
        r_word_data  <= w_justified;
        r_word_chan  <= r_chan;
        r_short_word <= w_pub_short;
        if (!r_chan) begin
          r_left_data <= w_justified;
          r_left_seen <= 1'b1;
        end else begin
          r_right_data <= w_justified;
          if (r_left_seen) begin
            r_frame_ready <= 1'b1;
            r_left_seen   <= 1'b0;
          end
        end
      end
    end
  end

  assign word_data   = r_word_data;
  assign word_chan   = r_word_chan;
  assign word_valid  = r_word_valid;
  assign short_word  = r_short_word;
  assign left_data   = r_left_data;
  assign right_data  = r_right_data;
  assign frame_ready = r_frame_ready;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rcvr_cntlr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_i2s_rcvr_cntlr                                    |
// | Description : Self-checking bench for i2s_rcvr_cntlr with a slot-  |
// |               level bit-queue reference model.                     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_i2s_rcvr_cntlr;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         sck_rise;
  logic         ws;
  logic         sd;
  logic [W-1:0] word_data;
  logic         word_chan;
  logic         word_valid;
  logic         short_word;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         frame_ready;

  i2s_rcvr_cntlr #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sck_rise    (sck_rise),
    .ws          (ws),
    .sd          (sd),
    .word_data   (word_data),
    .word_chan   (word_chan),
    .word_valid  (word_valid),
    .short_word  (short_word),
    .left_data   (left_data),
    .right_data  (right_data),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: slot bits are collected in a queue
  bit           m_started, m_synced, m_prev, m_chan, m_left_seen;
  bit           m_bits[$];
  logic         m_valid, m_fr, m_short, m_wchan;
  logic [W-1:0] m_data, m_left, m_right;

  // Observed history
  logic [W-1:0] last_data;
  logic         last_short, last_chan;
  int           obs_valid_cnt = 0;
  int           obs_fr_cnt    = 0;
  logic         pend = 1'b0;
  int           rel_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_synced = 0; m_prev = 0; m_chan = 0; m_left_seen = 0;
    m_bits.delete();
    m_valid = 0; m_fr = 0; m_short = 0; m_wchan = 0;
    m_data = '0; m_left = '0; m_right = '0;
  endtask

  task automatic model_emit(input bit is_short);
    logic [W-1:0] wd;
    wd = '0;
    for (int i = 0; i < m_bits.size() && i < W; i++) wd[W-1-i] = m_bits[i];
    m_valid = 1; m_data = wd; m_short = is_short; m_wchan = m_chan;
    if (!m_chan) begin
      m_left = wd; m_left_seen = 1;
    end else begin
      m_right = wd;
      if (m_left_seen) begin
        m_fr = 1; m_left_seen = 0;
      end
    end
  endtask

  task automatic model_edge(input bit w, input bit d);
    bit chg;
    m_valid = 0; m_fr = 0;
    if (!m_started) begin
      m_started = 1; m_prev = w;
    end else begin
      chg = (w != m_prev);
      m_prev = w;
      if (!m_synced) begin
        if (chg) begin
          m_synced = 1; m_bits.delete(); m_chan = w;
        end
      end else begin
        m_bits.push_back(d);
        if (chg) begin
          if (m_bits.size() <= W) model_emit(m_bits.size() < W);
          m_bits.delete();
          m_chan = w;
        end else if (m_bits.size() == W) begin
          model_emit(0);
        end
      end
    end
  endtask

  // One SCK rising edge, followed by sampling one clk after the pulse
  task automatic sck_edge(input logic w, input logic d);
    @(negedge clk);
    ws = w; sd = d; sck_rise = 1'b1;
    if (rst) model_reset();
    else     model_edge(w, d);
    @(negedge clk);
    sck_rise = 1'b0;
    check("word_valid", word_valid, m_valid);
    check("frame_ready", frame_ready, m_fr);
    if (m_valid) begin
      check("word_data", word_data, m_data);
      check("word_chan", word_chan, m_wchan);
      check("short_word", short_word, m_short);
    end
    check("left_data", left_data, m_left);
    check("right_data", right_data, m_right);
    if (word_valid === 1'b1) begin
      obs_valid_cnt++;
      last_data = word_data; last_short = short_word; last_chan = word_chan;
    end
    if (frame_ready === 1'b1) obs_fr_cnt++;
    @(negedge clk);
    @(negedge clk);
    if (rel_cnt > 0) begin
      rel_cnt--;
      if (rel_cnt == 0) rst = 1'b0;
    end
  endtask

  // A slot: edge 0 carries the previous slot's LSB, then the slot's bits
  task automatic send_slot(input logic w, input logic [63:0] bits, input int len);
    sck_edge(w, pend);
    for (int i = 0; i < len - 1; i++) sck_edge(w, bits[63-i]);
    pend = bits[64-len];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_data"}, word_data, 0);
    check({tag, "_word_valid"}, word_valid, 0);
    check({tag, "_short"}, short_word, 0);
    check({tag, "_left"}, left_data, 0);
    check({tag, "_right"}, right_data, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_chan"}, word_chan, 0);
  endtask

  int v0, f0;
  int lens [7] = '{1, 8, 12, 16, 17, 24, 32};

  initial begin
    rst = 1'b1; sck_rise = 1'b0; ws = 1'b0; sd = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Full 16-bit words
    v0 = obs_valid_cnt; f0 = obs_fr_cnt;
    send_slot(1'b1, {$urandom, $urandom}, 16);
    send_slot(1'b0, {16'hA5C3, 48'h0}, 16);
    send_slot(1'b1, {16'h0F81, 48'h0}, 16);
    send_slot(1'b0, {$urandom, $urandom}, 16);
    check("full_valid_cnt", obs_valid_cnt - v0, 2);
    check("full_fr_cnt", obs_fr_cnt - f0, 1);
    check("full_left", left_data, 16'hA5C3);
    check("full_right", right_data, 16'h0F81);

    // Long slots: 16 data bits then 16 trailing ones
    send_slot(1'b1, {$urandom, $urandom}, 16);
    send_slot(1'b0, {16'h1234, 16'hFFFF, 32'h0}, 32);
    check("long_left", left_data, 16'h1234);
    check("long_data", last_data, 16'h1234);
    check("long_short", last_short, 0);
    send_slot(1'b1, {$urandom, $urandom}, 32);

    // Short slots of 8 bits
    send_slot(1'b0, {8'hB7, 56'h0}, 8);
    send_slot(1'b1, {$urandom, $urandom}, 8);
    check("short_data", last_data, 16'hB700);
    check("short_flag", last_short, 1);
    check("short_chan", last_chan, 0);

    // Zero-bit slot: two WS changes back to back
    send_slot(1'b0, {1'b1, 63'h0}, 1);
    send_slot(1'b1, {$urandom, $urandom}, 16);
    check("zero_data", last_data, 16'h8000);
    check("zero_flag", last_short, 1);

    // Randomized slot lengths and contents
    for (int k = 0; k < 16; k++) begin
      send_slot(k[0], {$urandom, $urandom}, lens[$urandom_range(0, 6)]);
    end
    send_slot(1'b0, {$urandom, $urandom}, 16);

    // Asynchronous reset mid-word, released 5 edges into a left slot
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    rel_cnt = 5;
    v0 = obs_valid_cnt; f0 = obs_fr_cnt;
    send_slot(1'b0, {$urandom, $urandom}, 16);
    check("midframe_no_valid", obs_valid_cnt - v0, 0);
    send_slot(1'b1, {16'h5A3C, 48'h0}, 16);
    send_slot(1'b0, {$urandom, $urandom}, 16);
    check("midframe_valid_cnt", obs_valid_cnt - v0, 1);
    check("midframe_right", right_data, 16'h5A3C);
    check("midframe_left", left_data, 16'h0000);
    check("midframe_chan", last_chan, 1);
    check("right_only_fr", obs_fr_cnt - f0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
